// File: rtl/stepper_ramp_ctrl.sv
// Stepper motor sequencer: valid/ready move commands, wave/full/half-step coil drive,
// trapezoidal accel/decel step-rate ramp, absolute position tracking and abort.
module stepper_ramp_ctrl #(
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned ACCEL_STEP = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [1:0]        cmd_mode,
    input  logic [DIV_W-1:0]  cmd_start_period,
    input  logic [DIV_W-1:0]  cmd_min_period,
    input  logic              abort,
    input  logic              hold_en,
    output logic [3:0]        coils,
    output logic              step_pulse,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] position,
    output logic [STEP_W-1:0] steps_left
);

    localparam int unsigned   RW    = DIV_W + 1;
    localparam logic [RW-1:0] ACC_W = RW'(ACCEL_STEP);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [2:0]        idx_q;
    logic [STEP_W-1:0] position_q, steps_left_q, ramp_cnt_q;
    logic [DIV_W-1:0]  period_q, timer_q, start_q, min_q;
    logic              dir_q;
    logic [1:0]        mode_q;
    logic              done_q, step_pulse_q, aborted_q;

    logic              in_run, accept, timer_hit, step_fire, last_step;
    logic [STEP_W-1:0] rem;
    logic [DIV_W-1:0]  min_eff, start_eff, period_up, period_dn;
    logic [RW-1:0]     sum_up, min_plus;
    logic [2:0]        idx_inc, idx_raw, idx_nx;
    logic [3:0]        pattern;

    // Command decode, step timing, ramp arithmetic and phase advance
    always_comb begin
        in_run    = (state_q == ST_RUN);
        accept    = cmd_valid && !in_run;
        timer_hit = (timer_q == (period_q - DIV_W'(1)));
        step_fire = in_run && ena && !abort && timer_hit;
        rem       = steps_left_q - STEP_W'(1);
        last_step = (rem == '0);

        min_eff   = (cmd_min_period == '0) ? DIV_W'(1) : cmd_min_period;
        start_eff = (cmd_start_period > min_eff) ? cmd_start_period : min_eff;

        // One extra bit of headroom so the ramp saturates at its bounds instead of wrapping
        sum_up    = RW'(period_q) + ACC_W;
        period_up = (sum_up > RW'(start_q)) ? start_q : sum_up[DIV_W-1:0];
        min_plus  = RW'(min_q) + ACC_W;
        period_dn = (RW'(period_q) <= min_plus) ? min_q : DIV_W'(RW'(period_q) - ACC_W);

        idx_inc = (mode_q == 2'b10) ? 3'd1 : 3'd2;
        idx_raw = dir_q ? (idx_q + idx_inc) : (idx_q - idx_inc);
        case (mode_q)
            2'b10:   idx_nx = idx_raw;
            2'b00:   idx_nx = {idx_raw[2:1], 1'b0};
            default: idx_nx = {idx_raw[2:1], 1'b1};
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && (cmd_steps != '0)) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                       state_d = ST_IDLE;
                else if (step_fire && last_step) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Move datapath: command latch, timer, position and ramp state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            position_q   <= '0;
            steps_left_q <= '0;
            ramp_cnt_q   <= '0;
            period_q     <= '0;
            timer_q      <= '0;
            start_q      <= '0;
            min_q        <= '0;
            dir_q        <= 1'b0;
            mode_q       <= '0;
            done_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            if (accept) begin
                dir_q        <= cmd_dir;
                mode_q       <= cmd_mode;
                start_q      <= start_eff;
                min_q        <= min_eff;
                period_q     <= start_eff;
                ramp_cnt_q   <= '0;
                timer_q      <= '0;
                steps_left_q <= cmd_steps;
                aborted_q    <= 1'b0;
                if (cmd_steps == '0) done_q <= 1'b1;
            end else if (in_run) begin
                if (abort) begin
                    done_q    <= 1'b1;
                    aborted_q <= 1'b1;
                end else if (ena) begin
                    if (timer_hit) begin
                        timer_q      <= '0;
                        idx_q        <= idx_nx;
                        position_q   <= dir_q ? (position_q + STEP_W'(1))
                                              : (position_q - STEP_W'(1));
                        steps_left_q <= rem;
                        step_pulse_q <= 1'b1;
                        if (last_step) begin
                            done_q <= 1'b1;
                        end else if (rem <= ramp_cnt_q) begin
                            period_q   <= period_up;
                            ramp_cnt_q <= ramp_cnt_q - STEP_W'(1);
                        end else if (period_q > min_q) begin
                            period_q   <= period_dn;
                            ramp_cnt_q <= ramp_cnt_q + STEP_W'(1);
                        end
                    end else begin
                        timer_q <= timer_q + DIV_W'(1);
                    end
                end
            end
        end
    end

    // Phase table
    always_comb begin
        case (idx_q)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
    end

    assign busy       = in_run;
    assign cmd_ready  = ~in_run;
    assign coils      = (in_run || hold_en) ? pattern : 4'b0000;
    assign step_pulse = step_pulse_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign position   = position_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Directed bench for stepper_ramp_ctrl: ramp timing, step modes, hold, abort, ena gating,
// zero-length moves and asynchronous reset.
module tb_stepper_ramp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_start_period;
    logic [15:0] cmd_min_period;
    logic        abort;
    logic        hold_en;
    logic [3:0]  coils;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] position;
    logic [15:0] steps_left;

    stepper_ramp_ctrl #(.STEP_W(16), .DIV_W(16), .ACCEL_STEP(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
        .cmd_start_period(cmd_start_period), .cmd_min_period(cmd_min_period),
        .abort(abort), .hold_en(hold_en), .coils(coils), .step_pulse(step_pulse),
        .busy(busy), .done(done), .aborted(aborted),
        .position(position), .steps_left(steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t_acc = 0;
    int         step_q[$];
    int         done_q[$];
    logic [3:0] coil_q[$];
    bit         busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamps every step and done against the edge count
    always @(negedge clk) begin
        if (step_pulse) begin
            step_q.push_back(cyc);
            coil_q.push_back(coils);
        end
        if (done) done_q.push_back(cyc);
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int st(input int i);
        return (i < step_q.size()) ? step_q[i] : -1000;
    endfunction

    function automatic logic [3:0] cl(input int i);
        return (i < coil_q.size()) ? coil_q[i] : 4'bxxxx;
    endfunction

    function automatic int dn(input int i);
        return (i < done_q.size()) ? done_q[i] : -1000;
    endfunction

    task automatic clear_mon();
        step_q.delete();
        done_q.delete();
        coil_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic issue(input logic [15:0] steps, input logic dir, input logic [1:0] mode,
                         input logic [15:0] sp, input logic [15:0] mp);
        cmd_steps        = steps;
        cmd_dir          = dir;
        cmd_mode         = mode;
        cmd_start_period = sp;
        cmd_min_period   = mp;
        cmd_valid        = 1'b1;
        tick();
        t_acc     = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_steps(input int n, input int budget, input string tag);
        int k = 0;
        while (step_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(step_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
        cmd_mode = 2'b00; cmd_start_period = '0; cmd_min_period = '0;
        abort = 1'b0; hold_en = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_ready",     32'(cmd_ready),  32'd1);
        chk("rst_done",      32'(done),       32'd0);
        chk("rst_pulse",     32'(step_pulse), 32'd0);
        chk("rst_aborted",   32'(aborted),    32'd0);
        chk("rst_position",  32'(position),   32'd0);
        chk("rst_left",      32'(steps_left), 32'd0);
        chk("rst_coils_off", 32'(coils),      32'h0);
        hold_en = 1'b1;
        #1;
        chk("rst_coils_hold", 32'(coils), 32'h8);
        rst_n = 1'b1;
        tick();

        // Ramp: half, forward, 4 steps, start 10, min 4, accel 3
        clear_mon();
        issue(16'd4, 1'b1, 2'b10, 16'd10, 16'd4);
        chk("t1_busy", 32'(busy),       32'd1);
        chk("t1_left", 32'(steps_left), 32'd4);
        wait_steps(4, 100, "t1_timeout");
        chk("t1_int0",  32'(st(0) - t_acc), 32'd10);
        chk("t1_int1",  32'(st(1) - st(0)), 32'd7);
        chk("t1_int2",  32'(st(2) - st(1)), 32'd4);
        chk("t1_int3",  32'(st(3) - st(2)), 32'd7);
        chk("t1_coil0", 32'(cl(0)), 32'hC);
        chk("t1_coil1", 32'(cl(1)), 32'h4);
        chk("t1_coil2", 32'(cl(2)), 32'h6);
        chk("t1_coil3", 32'(cl(3)), 32'h2);
        chk("t1_done_at_last", 32'(dn(0) - st(3)), 32'd0);
        chk("t1_position", 32'(position), 32'd4);
        chk("t1_busy_end", 32'(busy),     32'd0);
        chk("t1_ready_end", 32'(cmd_ready), 32'd1);

        // Full, reverse, 3 steps from idx 0, constant period 5
        do_reset();
        clear_mon();
        issue(16'd3, 1'b0, 2'b01, 16'd5, 16'd5);
        wait_steps(3, 60, "t2_timeout");
        chk("t2_int0",  32'(st(0) - t_acc), 32'd5);
        chk("t2_int1",  32'(st(1) - st(0)), 32'd5);
        chk("t2_int2",  32'(st(2) - st(1)), 32'd5);
        chk("t2_coil0", 32'(cl(0)), 32'h9);
        chk("t2_coil1", 32'(cl(1)), 32'h3);
        chk("t2_coil2", 32'(cl(2)), 32'h6);
        chk("t2_position", 32'(position), 32'hFFFD);

        // Wave, forward, 2 steps from idx 3, no hold
        hold_en = 1'b0;
        tick();
        clear_mon();
        issue(16'd2, 1'b1, 2'b00, 16'd3, 16'd3);
        wait_steps(2, 40, "t3_timeout");
        chk("t3_coil0", 32'(cl(0)), 32'h2);
        chk("t3_coil1", 32'(cl(1)), 32'h0);
        chk("t3_coils_idle", 32'(coils), 32'h0);
        hold_en = 1'b1;
        #1;
        chk("t3_coils_hold", 32'(coils), 32'h1);
        chk("t3_position", 32'(position), 32'hFFFF);

        // Abort two cycles after the third step
        do_reset();
        clear_mon();
        issue(16'd100, 1'b1, 2'b10, 16'd8, 16'd8);
        wait_steps(3, 60, "t4_timeout");
        chk("t4_int2", 32'(st(2) - t_acc), 32'd24);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_done",     32'(done),       32'd1);
        chk("t4_aborted",  32'(aborted),    32'd1);
        chk("t4_busy",     32'(busy),       32'd0);
        chk("t4_left",     32'(steps_left), 32'd97);
        chk("t4_position", 32'(position),   32'd3);
        chk("t4_coils",    32'(coils),      32'h6);
        repeat (20) tick();
        chk("t4_no_more_steps", 32'(step_q.size()), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_idle_abort_done", 32'(done_q.size()), 32'd1);
        chk("t4_aborted_kept",    32'(aborted),       32'd1);

        // ena low for 5 cycles during a period-6 step
        hold_en = 1'b0;
        clear_mon();
        issue(16'd1, 1'b1, 2'b01, 16'd6, 16'd6);
        chk("t5_aborted_clr", 32'(aborted), 32'd0);
        tick();
        tick();
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        wait_steps(1, 30, "t5_timeout");
        chk("t5_int0", 32'(st(0) - t_acc), 32'd11);
        chk("t5_done_at_step", 32'(dn(0) - st(0)), 32'd0);

        // Zero-length move
        tick();
        clear_mon();
        issue(16'd0, 1'b1, 2'b10, 16'd4, 16'd4);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        tick();
        chk("t6_done_pulse", 32'(done), 32'd0);
        repeat (3) tick();
        chk("t6_busy_never", 32'(busy_seen),      32'd0);
        chk("t6_done_count", 32'(done_q.size()),  32'd1);

        // Asynchronous reset mid-move
        hold_en = 1'b1;
        clear_mon();
        issue(16'd10, 1'b1, 2'b10, 16'd4, 16'd4);
        repeat (6) tick();
        hold_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t7_busy",     32'(busy),       32'd0);
        chk("t7_position", 32'(position),   32'd0);
        chk("t7_left",     32'(steps_left), 32'd0);
        chk("t7_coils",    32'(coils),      32'h0);
        chk("t7_pulse",    32'(step_pulse), 32'd0);
        repeat (3) tick();
        chk("t7_steps_before", 32'(step_q.size()), 32'd1);
        chk("t7_no_done",      32'(done_q.size()), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_ramp_ctrl.md
# stepper_ramp_ctrl

Parametrised next-generation stepper motor sequencer for the Tiny Tapeout stepper tile. It accepts move commands over a valid/ready handshake and drives a 4-wire coil pattern in wave, full or half-step mode. Step rate follows a trapezoidal accel/decel ramp. It tracks an absolute position and signals completion or abort. It sits between the tile's command/IO decode and the coil output pins.

## Interface
- `STEP_W`, 16: width of step count, remaining count and position.
- `DIV_W`, 16: width of step period, counted in clock cycles.
- `ACCEL_STEP`, 16: amount the period is changed per step while ramping.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  timer enable; when low, the step timer freezes and all other logic runs.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  equals `~busy`.
- `cmd_steps`  in  STEP_W  step count; 0 means no motion.
- `cmd_dir`  in  1  1 = forward (phase index +), 0 = reverse.
- `cmd_mode`  in  2  00 = wave, 01 = full, 10 = half, 11 = full.
- `cmd_start_period`  in  DIV_W  initial and ceiling period.
- `cmd_min_period`  in  DIV_W  cruise (floor) period.
- `abort`  in  1  stop request.
- `hold_en`  in  1  keep coils energised while idle.
- `coils`  out  4  coil drive, bits [3:0] = A, B, A', B'.
- `step_pulse`  out  1  one-cycle pulse on every step.
- `busy`  out  1  move in progress.
- `done`  out  1  one-cycle pulse at move end (normal, abort or zero-length).
- `aborted`  out  1  last move ended by abort; cleared on next accept.
- `position`  out  STEP_W  absolute step count, modulo 2^STEP_W.
- `steps_left`  out  STEP_W  remaining steps.

## Operation
- Reset values:
  - idx = 0; busy, done, step_pulse, aborted = 0; position, steps_left = 0.
  - Period and ramp_cnt = 0.
  - `coils` = 1000 if `hold_en`, else 0000.
- Phase table on 3-bit idx: 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
- `coils` is combinational: table[idx] when `busy|hold_en`, else 0000.
- Index advance per step:
  - Half mode: idx ±1.
  - Wave mode: idx ±2, then bit0 forced to 0.
  - Full mode: idx ±2, then bit0 forced to 1.
  - idx wraps modulo 8.
- `position` changes ±1 per step in every mode.
- Accept occurs when `cmd_valid & cmd_ready`. On accept:
  - All command fields are latched and `aborted` is cleared.
  - period = max(start, min, 1), with min taken as max(min, 1).
  - ramp_cnt = 0 and timer = 0.
  - steps_left = `cmd_steps`. If `cmd_steps` is 0: `done` pulses next cycle and `busy` stays 0.
- States:
  - IDLE: goes to RUN on accept with steps ≠ 0.
  - RUN: goes to IDLE on the last step or on abort.
- In RUN, while `ena` is high, the timer increments each cycle. A step fires when timer == period−1; the timer then restarts at 0.
- On each step: idx, position, `step_pulse` and steps_left (−1) update. With r = remaining after this step:
  - r == 0: go to IDLE, `done`=1, `busy`=0.
  - else if r ≤ ramp_cnt: period = min(period+ACCEL_STEP, start), ramp_cnt −1.
  - else if period > min: period = max(period−ACCEL_STEP, min), ramp_cnt +1.
  - else: period unchanged.
- Ramp arithmetic is done DIV_W+1 bits wide, with saturation; no wrap.
- Abort in RUN:
  - Next edge: IDLE, `busy`=0, `done`=1, `aborted`=1.
  - idx, position and steps_left are frozen; coils hold the last pattern if `hold_en`.
  - Abort wins over a simultaneous step; that step is not taken.
  - Abort in IDLE is ignored.
- `cmd_valid` during RUN is not accepted and is not queued.
- `rst_n` low mid-move asynchronously returns everything to reset values. No pending step or `done` is emitted.

## Timing
- Accept at edge T: `busy`=1 from T.
- The first step (coil change plus `step_pulse`) is registered at edge T+period, provided `ena` was high throughout.
- Each `ena`=0 cycle adds one cycle of delay.
- Step k+1 comes exactly period_k cycles after step k.
- The final step, `done` and `busy`=0 appear in the same cycle, so `cmd_ready`=1 that cycle. The earliest next accept is at that cycle's edge.
- Zero-step command: `done` is high in the cycle after accept.
- Abort: `done` is high in the cycle after `abort` is sampled.

## Test plan
- Ramp check, with ACCEL_STEP=3, half mode, forward, steps=4, start=10, min=4:
  - Step intervals are 10, 7, 4, 7 cycles.
  - idx goes 0→1→2→3→4; position = 4.
  - `done` fires with the 4th step.
- Full mode, reverse, steps=3, start=min=5, from idx 0:
  - idx goes 7, 5, 3; coils 1001, 0011, 0110.
  - position = −3 (0xFFFD); each interval is 5 cycles.
- Wave mode plus idle hold:
  - After a 2-step forward move from idx 3: idx goes 4, 6.
  - With `hold_en`=0 after `done`, coils = 0000; raising `hold_en` gives 0001.
- Abort, steps=100, start=min=8:
  - Assert `abort` 2 cycles after the 3rd step.
  - Next cycle: `done`=1, `aborted`=1, steps_left=97, position=3, with no further steps.
- `ena` gating and zero steps:
  - Holding `ena`=0 for 5 cycles during a period=6 step delays that step by exactly 5 cycles.
  - steps=0 gives a `done` pulse on the next cycle with `busy` never high.
- Reset mid-move: pulling `rst_n` low during RUN returns all outputs to reset values with no clock edge, and no `done` is emitted.
